// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the binary number game round sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_LOAD,
        ST_ASK,
        ST_SHOW,
        ST_DONE
    } state_t;

    localparam logic [1:0] VERDICT_NONE    = 2'b00;
    localparam logic [1:0] VERDICT_OK      = 2'b01;
    localparam logic [1:0] VERDICT_WRONG   = 2'b10;
    localparam logic [1:0] VERDICT_TIMEOUT = 2'b11;

    localparam logic [3:0] SCORE_MAX = 4'd15;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Player, generator and status signals of the round sequencer.
interface game_round_ctrl_if #(
    parameter int NUM_W = 4
);
    logic             start;
    logic [NUM_W-1:0] guess;
    logic             submit;
    logic             gen_enable;
    logic [NUM_W-1:0] gen_result;
    logic [NUM_W-1:0] target;
    logic             target_valid;
    logic [3:0]       round_idx;
    logic [3:0]       score;
    logic [1:0]       verdict;
    logic             busy;
    logic             done;

    // Master is the surrounding system: player controls plus the generator.
    modport master (
        output start, guess, submit, gen_result,
        input  gen_enable, target, target_valid, round_idx, score, verdict, busy, done
    );

    modport slave (
        input  start, guess, submit, gen_result,
        output gen_enable, target, target_valid, round_idx, score, verdict, busy, done
    );
endinterface

// File: rtl/game_round_ctrl_timer.sv
// Loadable down-counter shared by the answer window and the verdict hold.
module round_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: requests a generator value per round, times the answer,
// scores it and walks through a fixed number of rounds.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int ROUNDS        = 8,
    parameter int NUM_W         = 4,
    parameter int ANSWER_CYCLES = 50_000_000,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int MAX_RETRY     = 3
) (
    input logic              clk,
    input logic              rst_n,
    game_round_ctrl_if.slave bus
);

    localparam int TIMER_W = $clog2(max_int(ANSWER_CYCLES, HOLD_CYCLES));
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_W-1:0]   r_target;
    logic [NUM_W-1:0]   w_target_next;
    logic [NUM_W-1:0]   r_prev_target;
    logic [NUM_W-1:0]   w_prev_target_next;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_next;
    logic [3:0]         r_round;
    logic [3:0]         w_round_next;
    logic [3:0]         r_score;
    logic [3:0]         w_score_next;
    logic [1:0]         r_verdict;
    logic [1:0]         w_verdict_next;
    logic               r_gen_enable;
    logic               r_target_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_timer_load;
    logic [TIMER_W-1:0] w_timer_value;
    logic               w_timer_zero;

    round_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_timer_load),
        .load_value(w_timer_value),
        .zero      (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_target       <= '0;
            r_prev_target  <= '0;
            r_retry        <= '0;
            r_round        <= '0;
            r_score        <= '0;
            r_verdict      <= VERDICT_NONE;
            r_gen_enable   <= 1'b0;
            r_target_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_target       <= w_target_next;
            r_prev_target  <= w_prev_target_next;
            r_retry        <= w_retry_next;
            r_round        <= w_round_next;
            r_score        <= w_score_next;
            r_verdict      <= w_verdict_next;
            // Status flags are decoded from the next state so they align with it.
            r_gen_enable   <= (w_state_next == ST_REQ);
            r_target_valid <= (w_state_next == ST_ASK);
            r_busy         <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
            r_done         <= (w_state_next == ST_DONE);
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_target_next      = r_target;
        w_prev_target_next = r_prev_target;
        w_retry_next       = r_retry;
        w_round_next       = r_round;
        w_score_next       = r_score;
        w_verdict_next     = r_verdict;
        w_timer_load       = 1'b0;
        w_timer_value      = '0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_score_next   = '0;
                    w_round_next   = '0;
                    w_verdict_next = VERDICT_NONE;
                    w_state_next   = ST_REQ;
                end
            end
            ST_REQ:    w_state_next = ST_SETTLE;
            ST_SETTLE: w_state_next = ST_LOAD;
            ST_LOAD: begin
                // A repeat of the last target is re-requested, but only a bounded number of times.
                if ((bus.gen_result == r_prev_target) &&
                    (r_retry < RETRY_W'(MAX_RETRY)) && (r_round != 4'd0)) begin
                    w_retry_next = r_retry + 1'b1;
                    w_state_next = ST_REQ;
                end else begin
                    w_target_next      = bus.gen_result;
                    w_prev_target_next = bus.gen_result;
                    w_retry_next       = '0;
                    w_timer_load       = 1'b1;
                    w_timer_value      = TIMER_W'(ANSWER_CYCLES - 1);
                    w_state_next       = ST_ASK;
                end
            end
            ST_ASK: begin
                if (bus.submit) begin
                    if (bus.guess == r_target) begin
                        w_verdict_next = VERDICT_OK;
                        if (r_score != SCORE_MAX) begin
                            w_score_next = r_score + 4'd1;
                        end
                    end else begin
                        w_verdict_next = VERDICT_WRONG;
                    end
                    w_timer_load  = 1'b1;
                    w_timer_value = TIMER_W'(HOLD_CYCLES - 1);
                    w_state_next  = ST_SHOW;
                end else if (w_timer_zero) begin
                    w_verdict_next = VERDICT_TIMEOUT;
                    w_timer_load   = 1'b1;
                    w_timer_value  = TIMER_W'(HOLD_CYCLES - 1);
                    w_state_next   = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_timer_zero) begin
                    if (r_round == 4'(ROUNDS - 1)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_round_next   = r_round + 4'd1;
                        w_verdict_next = VERDICT_NONE;
                        w_state_next   = ST_REQ;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.gen_enable   = r_gen_enable;
    assign bus.target       = r_target;
    assign bus.target_valid = r_target_valid;
    assign bus.round_idx    = r_round;
    assign bus.score        = r_score;
    assign bus.verdict      = r_verdict;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed and randomized checks of game_round_ctrl against a round-level model.
module tb_game_round_ctrl;
    import game_pkg::*;

    localparam int ROUNDS = 2;
    localparam int NUM_W  = 4;
    localparam int A      = 10;
    localparam int H      = 3;
    localparam int MR     = 3;

    logic clk;
    logic rst_n;

    game_round_ctrl_if #(.NUM_W(NUM_W)) bus ();

    game_round_ctrl #(
        .ROUNDS       (ROUNDS),
        .NUM_W        (NUM_W),
        .ANSWER_CYCLES(A),
        .HOLD_CYCLES  (H),
        .MAX_RETRY    (MR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Generator script for the current game and a log of request cycles.
    logic [3:0] script[$];
    int         gen_ptr = 0;
    int         req_log[$];

    // Round-level model state.
    int         m_round = 0;
    int         m_score = 0;
    logic [3:0] m_prev  = 0;
    int         m_ptr   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    // Plays the generator: a new script value on every enable rising edge.
    initial begin
        logic last;
        last = 1'b0;
        bus.gen_result = '0;
        forever begin
            @(negedge clk);
            if (bus.gen_enable && !last) begin
                bus.gen_result = (gen_ptr < script.size()) ? script[gen_ptr] : 4'd0;
                gen_ptr++;
                req_log.push_back(cyc);
            end
            last = bus.gen_enable;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gen_enable"}, 32'(bus.gen_enable), 0);
        chk({tag, "_target"}, 32'(bus.target), 0);
        chk({tag, "_target_valid"}, 32'(bus.target_valid), 0);
        chk({tag, "_round_idx"}, 32'(bus.round_idx), 0);
        chk({tag, "_score"}, 32'(bus.score), 0);
        chk({tag, "_verdict"}, 32'(bus.verdict), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    task automatic start_game();
        req_log.delete();
        gen_ptr = 0;
        m_ptr   = 0;
        m_round = 0;
        m_score = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_gen_enable", 32'(bus.gen_enable), 1);
        chk("start_score", 32'(bus.score), 0);
        chk("start_round", 32'(bus.round_idx), 0);
        chk("start_verdict", 32'(bus.verdict), 0);
        chk("start_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("gen_enable_one_cycle", 32'(bus.gen_enable), 0);
        $display("game start: script size %0d", script.size());
    endtask

    task automatic wait_target_valid(output bit ok);
        int w;
        w = 0;
        while (!bus.target_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        ok = bus.target_valid;
        if (!ok) chk("target_valid_wait", 0, 1);
    endtask

    // One round: d<0 means no submit; use_acc selects a correct guess.
    task automatic do_round(input int d, input bit use_acc, input logic [3:0] g);
        int         k;
        int         nreq;
        int         cnt;
        bit         ok;
        logic [3:0] acc;
        logic [3:0] gv;
        logic [1:0] exp_v;

        // A repeat of the last target is skipped, at most MR times; round 0 takes the first value.
        k = 0;
        if (m_round != 0) begin
            while (k < MR && script[m_ptr + k] == m_prev) k++;
        end
        acc   = script[m_ptr + k];
        nreq  = k + 1;
        m_ptr = m_ptr + nreq;

        wait_target_valid(ok);
        if (!ok) return;
        chk("target", 32'(bus.target), 32'(acc));
        chk("round_idx", 32'(bus.round_idx), 32'(m_round));
        chk("n_requests", 32'(req_log.size()), 32'(nreq));
        if (req_log.size() > 0) chk("req_to_valid", 32'(cyc - req_log[0]), 32'(3 * nreq));
        chk("ask_verdict", 32'(bus.verdict), 0);
        req_log.delete();
        m_prev = acc;

        if (d >= 0) begin
            gv = use_acc ? acc : g;
            repeat (d) @(negedge clk);
            bus.guess  = gv;
            bus.submit = 1'b1;
            @(negedge clk);
            bus.submit = 1'b0;
            exp_v = (gv == acc) ? VERDICT_OK : VERDICT_WRONG;
            if (gv == acc && m_score < 15) m_score++;
            chk("submit_verdict", 32'(bus.verdict), 32'(exp_v));
        end else begin
            gv  = 4'd0;
            cnt = 0;
            while (bus.verdict != VERDICT_TIMEOUT && cnt < A + 20) begin
                @(negedge clk);
                cnt++;
            end
            exp_v = VERDICT_TIMEOUT;
            chk("timeout_cycles", 32'(cnt), 32'(A));
        end
        chk("verdict_score", 32'(bus.score), 32'(m_score));
        chk("verdict_tv_low", 32'(bus.target_valid), 0);

        // A correct-looking submit during the hold must be ignored.
        bus.guess  = acc;
        bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
        cnt = 1;
        while (!(bus.gen_enable || bus.done) && cnt < H + 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("show_cycles", 32'(cnt), 32'(H));
        chk("show_score", 32'(bus.score), 32'(m_score));
        if (m_round == ROUNDS - 1) begin
            chk("done", 32'(bus.done), 1);
            chk("done_busy", 32'(bus.busy), 0);
            chk("done_verdict", 32'(bus.verdict), 32'(exp_v));
        end else begin
            chk("next_verdict_clear", 32'(bus.verdict), 0);
            chk("next_round_idx", 32'(bus.round_idx), 32'(m_round + 1));
            m_round++;
        end
        $display("round target=%0d requests=%0d delay=%0d guess=%0d verdict=%0d score=%0d",
                 acc, nreq, d, gv, exp_v, m_score);
    endtask

    initial begin
        bit ok;
        bus.start  = 1'b0;
        bus.submit = 1'b0;
        bus.guess  = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");
        bus.submit = 1'b1;
        @(negedge clk);
        bus.submit = 1'b0;
        chk("idle_submit_busy", 32'(bus.busy), 0);

        // Correct answer, then a repeat followed by a timeout.
        script = '{4'd5, 4'd5, 4'd3};
        start_game();
        do_round(2, 1'b1, 4'd0);
        do_round(-1, 1'b0, 4'd0);
        chk("game1_score", 32'(bus.score), 1);

        // Restart from DONE; constant generator output exhausts retries.
        script = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        start_game();
        do_round(0, 1'b1, 4'd0);
        do_round(4, 1'b1, 4'd0);
        chk("game2_score", 32'(bus.score), 2);

        // Wrong submit coinciding with timer expiry, then reset during round 1 ASK.
        script = '{4'd6, 4'd9};
        start_game();
        do_round(A - 1, 1'b0, 4'd4);
        wait_target_valid(ok);
        chk("r1_target_before_reset", 32'(bus.target), 9);
        chk("r1_round_before_reset", 32'(bus.round_idx), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_ask");
        @(negedge clk);
        rst_n  = 1'b1;
        m_prev = 4'd0;

        // Reset during REQ drops the enable immediately.
        script = '{4'd7};
        req_log.delete();
        gen_ptr   = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("req_gen_enable", 32'(bus.gen_enable), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_req_gen_enable", 32'(bus.gen_enable), 0);
        chk("abort_req_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Restart from round 0 after the abort.
        script = '{4'd2, 4'd2, 4'd11};
        start_game();
        do_round(3, 1'b1, 4'd0);
        do_round(5, 1'b0, 4'd1);

        // Randomized games.
        for (int gi = 0; gi < 8; gi++) begin
            logic [3:0] v0;
            script.delete();
            v0 = 4'($urandom_range(0, 15));
            script.push_back(v0);
            for (int j = 0; j < 4; j++) begin
                script.push_back(($urandom_range(0, 1) == 1) ? v0 : 4'($urandom_range(0, 15)));
            end
            start_game();
            for (int r = 0; r < ROUNDS; r++) begin
                int d;
                d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, A - 1));
                do_round(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
